// File: rtl/snoop_pkg.sv
// Shared types and constants for the three-processor MESI snooping system:
// sequencer states, step codes, field widths and MESI encodings.
package snoop_pkg;

  localparam int unsigned NPROC_C    = 3;
  localparam int unsigned PROC_W     = 2;
  localparam int unsigned STEP_W     = 3;
  localparam int unsigned NSTEP_DONE = 5;
  localparam int unsigned TAG_W      = 12;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BLOCK_W    = 28;
  localparam int unsigned MESI_W     = 3;

  localparam logic [PROC_W-1:0] PROC_ILLEGAL = 2'd3;

  localparam logic [STEP_W-1:0] STEP_NONE   = 3'd0;
  localparam logic [STEP_W-1:0] STEP_SHARE  = 3'd1;
  localparam logic [STEP_W-1:0] STEP_LOOKUP = 3'd2;
  localparam logic [STEP_W-1:0] STEP_SNOOP  = 3'd3;
  localparam logic [STEP_W-1:0] STEP_UPDATE = 3'd4;
  localparam logic [STEP_W-1:0] STEP_FILL   = 3'd5;
  localparam logic [STEP_W-1:0] STEP_DONE   = 3'd6;

  localparam logic [MESI_W-1:0] MESI_I = 3'd0;
  localparam logic [MESI_W-1:0] MESI_S = 3'd1;
  localparam logic [MESI_W-1:0] MESI_E = 3'd2;
  localparam logic [MESI_W-1:0] MESI_M = 3'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    S1_SHARE  = 3'd2,
    S2_LOOKUP = 3'd3,
    S3_SNOOP  = 3'd4,
    S4_UPDATE = 3'd5,
    S5_FILL   = 3'd6,
    S6_DONE   = 3'd7
  } state_t;

  typedef struct packed {
    logic [PROC_W-1:0] proc;
    logic              write;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } instr_t;

  function automatic logic [STEP_W-1:0] step_code(state_t s);
    case (s)
      S1_SHARE:  return STEP_SHARE;
      S2_LOOKUP: return STEP_LOOKUP;
      S3_SNOOP:  return STEP_SNOOP;
      S4_UPDATE: return STEP_UPDATE;
      S5_FILL:   return STEP_FILL;
      S6_DONE:   return STEP_DONE;
      default:   return STEP_NONE;
    endcase
  endfunction

  // True in the states where caches work on a step and may time out.
  function automatic logic is_step(state_t s);
    return (s == S1_SHARE) || (s == S2_LOOKUP) || (s == S3_SNOOP) ||
           (s == S4_UPDATE) || (s == S5_FILL);
  endfunction

endpackage

// File: rtl/snoop_bus_mux.sv
// Combinational snoop bus routing: requester exclusion for bus requests,
// shared-line OR toward the requester, and lowest-index block supplier select.
module snoop_bus_mux
  import snoop_pkg::*;
(
  input  logic [PROC_W-1:0]               req,
  input  logic                            share_active,
  input  logic                            bus_active,
  input  logic [NPROC_C-1:0]              shared_out,
  input  logic [NPROC_C-1:0]              send_read_miss,
  input  logic [NPROC_C-1:0]              send_write_miss,
  input  logic [NPROC_C-1:0]              send_invalidate,
  input  logic [NPROC_C-1:0]              write_en,
  input  logic [NPROC_C-1:0][BLOCK_W-1:0] block_out,
  output logic [NPROC_C-1:0]              req_oh_c,
  output logic [NPROC_C-1:0]              shared_in_c,
  output logic [NPROC_C-1:0]              bus_read_miss_c,
  output logic [NPROC_C-1:0]              bus_write_miss_c,
  output logic [NPROC_C-1:0]              bus_invalidate_c,
  output logic                            supply_valid_c,
  output logic [BLOCK_W-1:0]              supply_block_c,
  output logic                            req_wb_c,
  output logic [BLOCK_W-1:0]              req_block_c
);

  logic [NPROC_C-1:0] others;
  logic [NPROC_C-1:0] cand;
  logic               found;

  // An illegal requester decodes to no one-hot bit at all.
  always_comb begin
    req_oh_c = '0;
    for (int unsigned j = 0; j < NPROC_C; j++) begin
      if (req == PROC_W'(j)) req_oh_c[j] = 1'b1;
    end
  end

  assign others = ~req_oh_c;
  assign cand   = write_en & others;

  assign shared_in_c      = (share_active && |(shared_out & others)) ? req_oh_c : '0;
  assign bus_read_miss_c  = (bus_active && |(send_read_miss  & req_oh_c)) ? others : '0;
  assign bus_write_miss_c = (bus_active && |(send_write_miss & req_oh_c)) ? others : '0;
  assign bus_invalidate_c = (bus_active && |(send_invalidate & req_oh_c)) ? others : '0;

  assign supply_valid_c = |cand;
  assign req_wb_c       = |(write_en & req_oh_c);

  always_comb begin
    found          = 1'b0;
    supply_block_c = '0;
    req_block_c    = '0;
    for (int unsigned j = 0; j < NPROC_C; j++) begin
      if (cand[j] && !found) begin
        supply_block_c = block_out[j];
        found          = 1'b1;
      end
      if (req_oh_c[j]) req_block_c = block_out[j];
    end
  end

endmodule

// File: rtl/snoop_step_sequencer.sv
// Central step sequencer for the three MESI caches: accepts one instruction,
// walks the caches through steps 1..6 and owns the snoop bus and memory port.
module snoop_step_sequencer
  import snoop_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned NPROC          = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  input  logic [PROC_W-1:0]                   instr_proc,
  input  logic                                instr_write,
  input  logic [TAG_W-1:0]                    instr_tag,
  input  logic [DATA_W-1:0]                   instr_data,
  output logic [STEP_W-1:0]                   step,
  output logic [NPROC-1:0]                    cache_clear,
  output logic [NPROC-1:0]                    read_in,
  output logic [NPROC-1:0]                    write_in,
  output logic [TAG_W-1:0]                    tag_in,
  output logic [DATA_W-1:0]                   data_in,
  output logic [TAG_W-1:0]                    tag_b,
  input  logic [NPROC-1:0][NSTEP_DONE-1:0]    step_done,
  input  logic [NPROC-1:0]                    instr_done_in,
  input  logic [NPROC-1:0]                    shared_out,
  output logic [NPROC-1:0]                    shared_in,
  input  logic [NPROC-1:0]                    send_read_miss,
  input  logic [NPROC-1:0]                    send_write_miss,
  input  logic [NPROC-1:0]                    send_invalidate,
  output logic [NPROC-1:0]                    bus_read_miss,
  output logic [NPROC-1:0]                    bus_write_miss,
  output logic [NPROC-1:0]                    bus_invalidate,
  output logic [TAG_W-1:0]                    tag_bus,
  input  logic [NPROC-1:0][BLOCK_W-1:0]       block_out,
  input  logic [NPROC-1:0]                    write_en,
  output logic [BLOCK_W-1:0]                  block_in,
  input  logic [BLOCK_W-1:0]                  mem_rdata,
  output logic                                mem_we,
  output logic [BLOCK_W-1:0]                  mem_wdata,
  output logic                                result_valid,
  output logic                                result_err,
  output logic [PROC_W-1:0]                   result_proc
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t               state, state_n;
  instr_t               instr_q, instr_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 err_q, err_n;
  logic                 wr_done_q, wr_done_n;
  logic                 supplied_q, supplied_n;
  logic [BLOCK_W-1:0]   fill_q, fill_n;

  logic                 instr_ready_n, mem_we_n;
  logic                 result_valid_n, result_err_n;
  logic [PROC_W-1:0]    result_proc_n;
  logic [STEP_W-1:0]    step_n;
  logic [NPROC-1:0]     cache_clear_n, read_in_n, write_in_n;
  logic [TAG_W-1:0]     tag_in_n, tag_b_n, tag_bus_n;
  logic [DATA_W-1:0]    data_in_n;
  logic [BLOCK_W-1:0]   mem_wdata_n;

  logic [NSTEP_DONE-1:0] done_all;
  logic                  step_ok, timeout, hit, act;
  logic [NPROC-1:0]      req_oh_c;
  logic                  supply_valid_c, req_wb_c;
  logic [BLOCK_W-1:0]    supply_block_c, req_block_c;

  snoop_bus_mux u_bus_mux (
    .req              (instr_q.proc),
    .share_active     (is_step(state)),
    .bus_active       ((state == S3_SNOOP) || (state == S4_UPDATE)),
    .shared_out       (shared_out),
    .send_read_miss   (send_read_miss),
    .send_write_miss  (send_write_miss),
    .send_invalidate  (send_invalidate),
    .write_en         (write_en),
    .block_out        (block_out),
    .req_oh_c         (req_oh_c),
    .shared_in_c      (shared_in),
    .bus_read_miss_c  (bus_read_miss),
    .bus_write_miss_c (bus_write_miss),
    .bus_invalidate_c (bus_invalidate),
    .supply_valid_c   (supply_valid_c),
    .supply_block_c   (supply_block_c),
    .req_wb_c         (req_wb_c),
    .req_block_c      (req_block_c)
  );

  // Per-step AND of the done flags across all caches.
  always_comb begin
    done_all = '1;
    for (int unsigned p = 0; p < NPROC; p++) done_all &= step_done[p];
  end

  always_comb begin
    case (state)
      S1_SHARE:  step_ok = done_all[0];
      S2_LOOKUP: step_ok = done_all[1];
      S3_SNOOP:  step_ok = done_all[2];
      S4_UPDATE: step_ok = done_all[3];
      S5_FILL:   step_ok = done_all[4];
      default:   step_ok = 1'b0;
    endcase
  end

  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign hit     = |(instr_done_in & req_oh_c);

  // Fill block: live selection while in S4, the latched choice during S5.
  always_comb begin
    case (state)
      S4_UPDATE: block_in = supplied_q     ? fill_q :
                            supply_valid_c ? supply_block_c : mem_rdata;
      S5_FILL:   block_in = fill_q;
      default:   block_in = '0;
    endcase
  end

  always_comb begin
    state_n     = state;
    instr_n     = instr_q;
    err_n       = err_q;
    supplied_n  = supplied_q;
    fill_n      = fill_q;
    mem_we_n    = 1'b0;
    mem_wdata_n = mem_wdata;

    case (state)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          state_n       = CLEAR;
          instr_n.proc  = instr_proc;
          instr_n.write = instr_write;
          instr_n.tag   = instr_tag;
          instr_n.data  = instr_data;
          err_n         = 1'b0;
          supplied_n    = 1'b0;
          fill_n        = '0;
        end
      end
      CLEAR: begin
        if (instr_q.proc == PROC_ILLEGAL) begin
          state_n = S6_DONE;
          err_n   = 1'b1;
        end else begin
          state_n = S1_SHARE;
        end
      end
      S1_SHARE:  if (step_ok) state_n = S2_LOOKUP;
      S2_LOOKUP: if (step_ok) state_n = hit ? S6_DONE : S3_SNOOP;
      S3_SNOOP:  if (step_ok) state_n = S4_UPDATE;
      S4_UPDATE: begin
        if (!supplied_q) begin
          supplied_n = supply_valid_c;
          fill_n     = supply_valid_c ? supply_block_c : mem_rdata;
        end
        // A supplier was in M, so its block also goes back to memory.
        if (supply_valid_c && !wr_done_q) begin
          mem_we_n    = 1'b1;
          mem_wdata_n = supply_block_c;
        end
        if (step_ok) state_n = S5_FILL;
      end
      S5_FILL: begin
        if (req_wb_c && !wr_done_q) begin
          mem_we_n    = 1'b1;
          mem_wdata_n = req_block_c;
        end
        if (step_ok) state_n = S6_DONE;
      end
      S6_DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (is_step(state) && !step_ok && timeout) begin
      state_n = S6_DONE;
      err_n   = 1'b1;
    end

    wr_done_n = (state_n != state) ? 1'b0 : (wr_done_q | mem_we_n);
    cnt_n     = ((state_n != state) || !is_step(state_n)) ? '0 : cnt + CNT_W'(1);

    // Registered outputs follow the state being entered.
    act            = is_step(state_n);
    instr_ready_n  = (state_n == IDLE);
    cache_clear_n  = (state_n == CLEAR) ? '1 : '0;
    step_n         = (instr_n.proc == PROC_ILLEGAL) ? STEP_NONE : step_code(state_n);
    read_in_n      = (act && !instr_q.write) ? req_oh_c : '0;
    write_in_n     = (act &&  instr_q.write) ? req_oh_c : '0;
    tag_in_n       = act ? instr_q.tag : '0;
    tag_b_n        = act ? instr_q.tag : '0;
    data_in_n      = act ? instr_q.data : '0;
    tag_bus_n      = ((state_n == S3_SNOOP) || (state_n == S4_UPDATE)) ? instr_q.tag : '0;
    result_valid_n = (state_n == S6_DONE);
    result_err_n   = (state_n == S6_DONE) && err_n;
    result_proc_n  = (state_n == S6_DONE) ? instr_q.proc : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      instr_q      <= '0;
      cnt          <= '0;
      err_q        <= 1'b0;
      wr_done_q    <= 1'b0;
      supplied_q   <= 1'b0;
      fill_q       <= '0;
      instr_ready  <= 1'b0;
      step         <= STEP_NONE;
      cache_clear  <= '1;
      read_in      <= '0;
      write_in     <= '0;
      tag_in       <= '0;
      tag_b        <= '0;
      data_in      <= '0;
      tag_bus      <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
      result_proc  <= '0;
    end else begin
      state        <= state_n;
      instr_q      <= instr_n;
      cnt          <= cnt_n;
      err_q        <= err_n;
      wr_done_q    <= wr_done_n;
      supplied_q   <= supplied_n;
      fill_q       <= fill_n;
      instr_ready  <= instr_ready_n;
      step         <= step_n;
      cache_clear  <= cache_clear_n;
      read_in      <= read_in_n;
      write_in     <= write_in_n;
      tag_in       <= tag_in_n;
      tag_b        <= tag_b_n;
      data_in      <= data_in_n;
      tag_bus      <= tag_bus_n;
      mem_we       <= mem_we_n;
      mem_wdata    <= mem_wdata_n;
      result_valid <= result_valid_n;
      result_err   <= result_err_n;
      result_proc  <= result_proc_n;
    end
  end

endmodule

// File: tb/tb_snoop_step_sequencer.sv
// Directed bench for snoop_step_sequencer: read hit, shared miss, M supply,
// requester writeback, timeout, reset mid-instruction and illegal requester.
module tb_snoop_step_sequencer;
  import snoop_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              instr_valid, instr_ready, instr_write;
  logic [1:0]        instr_proc;
  logic [11:0]       instr_tag;
  logic [15:0]       instr_data;
  logic [2:0]        step, cache_clear, read_in, write_in;
  logic [11:0]       tag_in, tag_b, tag_bus;
  logic [15:0]       data_in;
  logic [2:0][4:0]   step_done;
  logic [2:0]        instr_done_in, shared_out, shared_in;
  logic [2:0]        send_read_miss, send_write_miss, send_invalidate;
  logic [2:0]        bus_read_miss, bus_write_miss, bus_invalidate;
  logic [2:0][27:0]  block_out;
  logic [2:0]        write_en;
  logic [27:0]       block_in, mem_rdata, mem_wdata;
  logic              mem_we, result_valid, result_err;
  logic [1:0]        result_proc;

  snoop_step_sequencer dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_proc(instr_proc), .instr_write(instr_write),
    .instr_tag(instr_tag), .instr_data(instr_data),
    .step(step), .cache_clear(cache_clear),
    .read_in(read_in), .write_in(write_in),
    .tag_in(tag_in), .data_in(data_in), .tag_b(tag_b),
    .step_done(step_done), .instr_done_in(instr_done_in),
    .shared_out(shared_out), .shared_in(shared_in),
    .send_read_miss(send_read_miss), .send_write_miss(send_write_miss),
    .send_invalidate(send_invalidate),
    .bus_read_miss(bus_read_miss), .bus_write_miss(bus_write_miss),
    .bus_invalidate(bus_invalidate), .tag_bus(tag_bus),
    .block_out(block_out), .write_en(write_en), .block_in(block_in),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .result_valid(result_valid), .result_err(result_err),
    .result_proc(result_proc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-instruction observations.
  int          lat, nwe, s3_cyc;
  logic        got_valid, saw_bus, err, rdy_c1;
  logic [1:0]  rproc;
  logic [2:0]  step_or, rd_s1, wr_s1, shin_s1, brm_s3, bwm_s3, brm_s4;
  logic [11:0] tbus_s3;
  logic [27:0] blk_s4, blk_s5, last_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_instr(input logic [1:0] p, input logic w, input logic [11:0] t,
                           input logic [15:0] d);
    int n;
    n = 0;
    while (!instr_ready && n < 30) begin
      tick();
      n++;
    end
    lat = 0; nwe = 0; s3_cyc = -1; got_valid = 1'b0; saw_bus = 1'b0; err = 1'b0;
    rdy_c1 = 1'b1; rproc = '0; step_or = '0; rd_s1 = '0; wr_s1 = '0; shin_s1 = '0;
    brm_s3 = '0; bwm_s3 = '0; brm_s4 = '0; tbus_s3 = '0; blk_s4 = '0; blk_s5 = '0;
    last_wdata = '0;
    instr_valid = 1'b1; instr_proc = p; instr_write = w; instr_tag = t; instr_data = d;
    tick();
    instr_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) tick();
      if (c == 1) rdy_c1 = instr_ready;
      step_or |= step;
      if ((bus_read_miss | bus_write_miss | bus_invalidate) != 3'b000) saw_bus = 1'b1;
      if (mem_we) begin
        nwe++;
        last_wdata = mem_wdata;
      end
      if (step == 3'd1) begin rd_s1 = read_in; wr_s1 = write_in; shin_s1 = shared_in; end
      if (step == 3'd3) begin
        if (s3_cyc < 0) s3_cyc = c;
        brm_s3 = bus_read_miss; bwm_s3 = bus_write_miss; tbus_s3 = tag_bus;
      end
      if (step == 3'd4) begin brm_s4 = bus_read_miss; blk_s4 = block_in; end
      if (step == 3'd5) blk_s5 = block_in;
      if (result_valid) begin
        got_valid = 1'b1; lat = c; err = result_err; rproc = result_proc;
        break;
      end
    end
    check("result_seen", 32'(got_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_proc = '0; instr_write = 1'b0;
    instr_tag = '0; instr_data = '0; step_done = '1; instr_done_in = '0;
    shared_out = '0; send_read_miss = '0; send_write_miss = '0; send_invalidate = '0;
    block_out = '0; write_en = '0; mem_rdata = 28'h1100AAA;

    tick(); tick();
    check("rst_step", 32'(step), 32'd0);
    check("rst_cache_clear", 32'(cache_clear), 32'h7);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_block_in", 32'(block_in), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    check("post_rst_cache_clear", 32'(cache_clear), 32'h0);

    // Read hit in cache0: S2 short-cut.
    instr_done_in = 3'b001;
    run_instr(2'd0, 1'b0, 12'h120, 16'h0);
    check("hit_latency", 32'(lat), 32'd4);
    check("hit_ready_busy", 32'(rdy_c1), 32'd0);
    check("hit_no_mem_we", 32'(nwe), 32'd0);
    check("hit_no_bus", 32'(saw_bus), 32'd0);
    check("hit_err", 32'(err), 32'd0);
    check("hit_read_in", 32'(rd_s1), 32'h1);
    tick();
    check("hit_back_idle", 32'(instr_ready), 32'd1);
    instr_done_in = '0;

    // Shared read miss from P2, cache0 holds the line.
    shared_out = 3'b001; send_read_miss = 3'b100;
    run_instr(2'd2, 1'b0, 12'h110, 16'h0);
    check("srm_latency", 32'(lat), 32'd7);
    check("srm_shared_in", 32'(shin_s1), 32'h4);
    check("srm_read_in", 32'(rd_s1), 32'h4);
    check("srm_bus_rm_s3", 32'(brm_s3), 32'h3);
    check("srm_bus_rm_s4", 32'(brm_s4), 32'h3);
    check("srm_tag_bus", 32'(tbus_s3), 32'h110);
    check("srm_block_s4", 32'(blk_s4), 32'h1100AAA);
    check("srm_block_s5", 32'(blk_s5), 32'h1100AAA);
    check("srm_no_mem_we", 32'(nwe), 32'd0);
    check("srm_proc", 32'(rproc), 32'd2);
    shared_out = '0; send_read_miss = '0;

    // P1 write miss, cache0 supplies its M block.
    send_write_miss = 3'b010; write_en = 3'b001;
    block_out[0] = 28'h1080055; block_out[1] = 28'h0BEEF01;
    run_instr(2'd1, 1'b1, 12'h108, 16'h5A5A);
    check("sup_latency", 32'(lat), 32'd7);
    check("sup_write_in", 32'(wr_s1), 32'h2);
    check("sup_bus_wm", 32'(bwm_s3), 32'h5);
    check("sup_bus_rm", 32'(brm_s3), 32'h0);
    check("sup_block_s4", 32'(blk_s4), 32'h1080055);
    check("sup_block_s5", 32'(blk_s5), 32'h1080055);
    check("sup_mem_we_cnt", 32'(nwe), 32'd1);
    check("sup_mem_wdata", 32'(last_wdata), 32'h1080055);
    send_write_miss = '0;

    // Requester P0 evicts a dirty block in S5; fill comes from memory.
    send_read_miss = 3'b001; block_out[0] = 28'h0123456;
    run_instr(2'd0, 1'b0, 12'h0F0, 16'h0);
    check("wb_bus_rm", 32'(brm_s3), 32'h6);
    check("wb_block_s4", 32'(blk_s4), 32'h1100AAA);
    check("wb_mem_we_cnt", 32'(nwe), 32'd1);
    check("wb_mem_wdata", 32'(last_wdata), 32'h0123456);
    send_read_miss = '0; write_en = '0; block_out = '0;

    // Cache1 never finishes step 3.
    step_done[1][2] = 1'b0;
    run_instr(2'd1, 1'b0, 12'h0A0, 16'h0);
    check("to_s3_entry", 32'(s3_cyc), 32'd4);
    check("to_delay", 32'(lat - s3_cyc), 32'd15);
    check("to_err", 32'(err), 32'd1);
    check("to_proc", 32'(rproc), 32'd1);
    tick();
    check("to_idle_ready", 32'(instr_ready), 32'd1);
    check("to_idle_step", 32'(step), 32'd0);
    step_done = '1;

    // Reset while in S3.
    instr_valid = 1'b1; instr_proc = 2'd0; instr_write = 1'b0; instr_tag = 12'h120;
    tick();
    instr_valid = 1'b0;
    for (int c = 0; c < 10 && step != 3'd3; c++) tick();
    check("mid_reach_s3", 32'(step), 32'd3);
    reset = 1'b1;
    tick();
    check("mid_step", 32'(step), 32'd0);
    check("mid_cache_clear", 32'(cache_clear), 32'h7);
    check("mid_result_valid", 32'(result_valid), 32'd0);
    check("mid_mem_we", 32'(mem_we), 32'd0);
    reset = 1'b0;
    tick();
    check("mid_after_valid", 32'(result_valid), 32'd0);
    check("mid_after_ready", 32'(instr_ready), 32'd1);
    instr_done_in = 3'b001;
    run_instr(2'd0, 1'b0, 12'h120, 16'h0);
    check("mid_next_latency", 32'(lat), 32'd4);
    check("mid_next_err", 32'(err), 32'd0);
    instr_done_in = '0;

    // Illegal requester.
    run_instr(2'd3, 1'b0, 12'h055, 16'h0);
    check("ill_latency", 32'(lat), 32'd2);
    check("ill_err", 32'(err), 32'd1);
    check("ill_no_step", 32'(step_or), 32'd0);
    check("ill_no_mem_we", 32'(nwe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snoop_step_sequencer.md
# snoop_step_sequencer

Central sequencer and bus multiplexer for the three-processor MESI snooping system. It accepts one memory instruction at a time from the processor-side instruction source, drives the common `step` code (1..6) to all three per-processor caches, and gathers their step-done flags. It routes the requester's miss/invalidate requests onto the snoop bus as broadcasts, and selects the fill block from either a supplying cache or memory. It is the upstream stage of every cache instance and the only writer of the memory port.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 15: maximum number of cycles to wait for all done flags in one step.
- `NPROC`, default 3: number of caches. It is fixed at 3; other values are unsupported.

Ports:
- `clock` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` / `instr_ready` in/out 1: instruction handshake. An instruction transfers when both are high on a clock edge.
- `instr_proc` in 2: requesting processor, 0..2. The value 3 is illegal.
- `instr_write` in 1: 1 = write, 0 = read.
- `instr_tag` in 12, `instr_data` in 16: address tag and write data.
- `step` out 3: step code broadcast to all caches. 0 means no step is active.
- `cache_clear` out 3: per-cache flag clear, connected to each cache's `reset`.
- `read_in`, `write_in` out 3: one-hot, asserted only for the requester.
- `tag_in` out 12, `data_in` out 16, `tag_b` out 12: instruction fields, broadcast to all caches.
- `step_done` in 3×5: per-cache `step1Done`..`step5Done`.
- `instr_done_in` in 3: per-cache `instrDone`.
- `shared_out` in 3: per-cache sharing indication.
- `shared_in` out 3: wired-OR of the non-requester `shared_out` bits, delivered to the requester only.
- `send_read_miss`, `send_write_miss`, `send_invalidate` in 3: requests from each cache.
- `bus_read_miss`, `bus_write_miss`, `bus_invalidate` out 3: the requester's request, driven to non-requesters only.
- `tag_bus` out 12: snoop tag.
- `block_out` in 3×28: block from each cache.
- `write_en` in 3: per-cache supply/writeback strobe.
- `block_in` out 28: fill block delivered to all caches.
- `mem_rdata` in 28: memory block for `tag_bus`. Memory is combinational.
- `mem_we` out 1, `mem_wdata` out 28: memory write port.
- `result_valid` out 1: one-cycle completion pulse.
- `result_err` out 1: completion with timeout.
- `result_proc` out 2: requester of the completed instruction.

## Operation

- **States:** IDLE, CLEAR, S1_SHARE, S2_LOOKUP, S3_SNOOP, S4_UPDATE, S5_FILL, S6_DONE. The `step` output is 0 in IDLE and CLEAR, and 1..6 in S1..S6.
- **IDLE:** `instr_ready`=1. On transfer, latch proc/write/tag/data, then go to CLEAR.
- **CLEAR:** `cache_clear`=3'b111 for exactly one cycle, then go to S1.
- **S1 to S5 advance rule:** advance when the AND of `step_done[k]` across all three caches is 1.
- **S2 hit short-cut:** in S2, if `instr_done_in[req]`=1 together with the S2 done condition, go directly to S6.
- **S3 and S4:** drive `tag_bus`=tag and `bus_*` from the latched request. Each `bus_*` output for cache j is `send_*[req]` AND (j≠req).
- **S4 supply:** if any non-requester `write_en[j]` is high, `block_in` is latched from `block_out[j]` (lowest j wins). `mem_we` pulses once with that block, because the supplying cache was in M and its data goes back to memory. Otherwise `block_in`=`mem_rdata`.
- **S5 writeback:** if `write_en[req]`, `mem_we` pulses once with `mem_wdata`=`block_out[req]`.
- **S6:** hold for one cycle and pulse `result_valid`. Then go to IDLE.
- **Timeout:** a per-step counter resets on every state entry. When it reaches `TIMEOUT_CYCLES` without the advance condition, jump to S6 with `result_err`=1.
- **`shared_in`:** combinational from the latched requester. It is 0 outside S1..S5.
- **Illegal `instr_proc`=3:** `instr_ready` still accepts the instruction. The block goes straight to S6 with `result_err`=1 and issues no cache steps.

## Timing

- **Registered outputs:** all outputs are registered except `shared_in`, the `bus_*` outputs and `block_in` routing, which decode from registered state.
- **Reset values:**
  - `step`, `read_in`, `write_in`, `bus_*`, `mem_we`, `result_*`, `tag_*`, `data_in`, `block_in` and `mem_wdata` are all 0.
  - `cache_clear`=3'b111.
  - `instr_ready`=0 during reset, then 1 from the first cycle after reset.
  - State is IDLE.
- **Reset mid-instruction:** abandon the instruction with no `result_valid`, and issue no memory write in that cycle.
- **Step duration:** each step lasts at least 1 cycle. The minimum instruction latency from accept to `result_valid` is 7 cycles (CLEAR + S1..S6) for a full sequence, and 4 cycles for a read hit.
- **`mem_we` pulses:** `mem_we` pulses at most once per state. At most two pulses occur per instruction (S4 supply and S5 writeback).
- **Back-to-back instructions:** a new instruction can be accepted on the cycle after S6. `instr_ready`=0 from accept until IDLE.

## Structure

- **Shared package `snoop_pkg`:**
  - State enum.
  - Step code constants STEP_SHARE=1 … STEP_DONE=6.
  - Width constants TAG_W=12, DATA_W=16, BLOCK_W=28, MESI_W=3.
  - MESI encodings, shared with the cache and MESI machines.
- **Sub-module `snoop_bus_mux`:** one natural combinational sub-module. It covers requester exclusion for `bus_*`, the `shared_in` OR, and the lowest-index supplier select.

## Test plan

- **Read hit:** reset, then P0 reads tag 0x120 with cache0 holding S. Require: S2 short-cut, `result_valid` 4 cycles after accept, no `mem_we`, no `bus_*` asserted.
- **Shared read miss:** P2 reads 0x110 while cache0 `shared_out`=1 and `send_read_miss[2]`=1. Require: `shared_in`=3'b100, `bus_read_miss`=3'b011 in S3/S4, `block_in`=`mem_rdata`.
- **Supply from M:** P1 writes 0x108 while cache0 asserts `write_en` with `block_out`=0x1080055. Require: `block_in`=0x1080055, one `mem_we` in S4, `bus_write_miss`=3'b101.
- **Timeout:** cache1 never raises `step3Done`. Require: `result_err`=1 and `result_valid` 15 cycles after S3 entry, then IDLE.
- **Reset mid-instruction:** assert reset during S3. Require: next cycle `step`=0, `cache_clear`=3'b111, no `result_valid`. The next instruction runs normally.
- **Illegal requester:** `instr_proc`=3. Require: `result_err` pulse 2 cycles after accept, `step` never nonzero.
